// File: rtl/ws2812_rx_decoder.sv
// WS2812 single-wire receiver: measures pulse widths on din, rebuilds pixel words
// tagged with their LED index and reports the latch gap as end-of-frame.
module ws2812_rx_decoder #(
  parameter int unsigned T_MIN_HIGH     = 15,
  parameter int unsigned T_SPLIT        = 60,
  parameter int unsigned T_MAX_HIGH     = 120,
  parameter int unsigned T_LATCH        = 5000,
  parameter int unsigned PX_COUNT       = 52,
  parameter int unsigned BITS_PER_PIXEL = 24,
  parameter int unsigned PX_IDX_W       = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      din,
  output logic [BITS_PER_PIXEL-1:0] pixel_out,
  output logic [PX_IDX_W-1:0]       pixel_idx,
  output logic                      pixel_valid,
  output logic                      frame_done,
  output logic [PX_IDX_W:0]         frame_px_count,
  output logic                      err_pulse
);

  localparam int unsigned HW = $clog2(T_MAX_HIGH + 2);
  localparam int unsigned LW = $clog2(T_LATCH + 1);
  localparam int unsigned BW = $clog2(BITS_PER_PIXEL + 1);
  localparam int unsigned CW = PX_IDX_W + 1;

  localparam logic [HW-1:0] H_MIN   = HW'(T_MIN_HIGH);
  localparam logic [HW-1:0] H_SPLIT = HW'(T_SPLIT);
  localparam logic [HW-1:0] H_MAX   = HW'(T_MAX_HIGH);
  localparam logic [HW-1:0] H_SAT   = HW'(T_MAX_HIGH + 1);
  localparam logic [LW-1:0] L_SAT   = LW'(T_LATCH);
  localparam logic [LW-1:0] L_ARM   = LW'(T_LATCH - 1);
  localparam logic [BW-1:0] B_LAST  = BW'(BITS_PER_PIXEL - 1);
  localparam logic [CW-1:0] C_MAX   = CW'(PX_COUNT);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t                    state_q, state_d;
  logic                      din_meta_q, din_s_q, din_d_q;
  logic [HW-1:0]             hcnt_q, hcnt_d;
  logic [LW-1:0]             lcnt_q, lcnt_d;
  logic [BITS_PER_PIXEL-1:0] sreg_q, sreg_d;
  logic [BW-1:0]             bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]             px_cnt_q, px_cnt_d;
  logic [BITS_PER_PIXEL-1:0] pixel_out_q, pixel_out_d;
  logic [PX_IDX_W-1:0]       pixel_idx_q, pixel_idx_d;
  logic                      pixel_valid_q, pixel_valid_d;
  logic                      frame_done_q, frame_done_d;
  logic [CW-1:0]             frame_px_count_q, frame_px_count_d;
  logic                      err_q, err_d;

  logic                      rise, fall, latch_evt, resync;
  logic [BITS_PER_PIXEL-1:0] shifted;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= SYNC;
      din_meta_q       <= 1'b0;
      din_s_q          <= 1'b0;
      din_d_q          <= 1'b0;
      hcnt_q           <= '0;
      lcnt_q           <= '0;
      sreg_q           <= '0;
      bit_cnt_q        <= '0;
      px_cnt_q         <= '0;
      pixel_out_q      <= '0;
      pixel_idx_q      <= '0;
      pixel_valid_q    <= 1'b0;
      frame_done_q     <= 1'b0;
      frame_px_count_q <= '0;
      err_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      din_meta_q       <= din;
      din_s_q          <= din_meta_q;
      din_d_q          <= din_s_q;
      hcnt_q           <= hcnt_d;
      lcnt_q           <= lcnt_d;
      sreg_q           <= sreg_d;
      bit_cnt_q        <= bit_cnt_d;
      px_cnt_q         <= px_cnt_d;
      pixel_out_q      <= pixel_out_d;
      pixel_idx_q      <= pixel_idx_d;
      pixel_valid_q    <= pixel_valid_d;
      frame_done_q     <= frame_done_d;
      frame_px_count_q <= frame_px_count_d;
      err_q            <= err_d;
    end
  end

  // hcnt holds its last value through the low phase so it still reads the
  // finished pulse width on the falling-edge cycle.
  always_comb begin
    rise = din_s_q & ~din_d_q;
    fall = ~din_s_q & din_d_q;

    hcnt_d = hcnt_q;
    if (rise)
      hcnt_d = HW'(1);
    else if (din_s_q && (hcnt_q != H_SAT))
      hcnt_d = hcnt_q + HW'(1);

    lcnt_d = lcnt_q;
    if (din_s_q)
      lcnt_d = '0;
    else if (lcnt_q != L_SAT)
      lcnt_d = lcnt_q + LW'(1);
  end

  always_comb begin
    state_d          = state_q;
    sreg_d           = sreg_q;
    bit_cnt_d        = bit_cnt_q;
    px_cnt_d         = px_cnt_q;
    pixel_out_d      = pixel_out_q;
    pixel_idx_d      = pixel_idx_q;
    pixel_valid_d    = 1'b0;
    frame_done_d     = 1'b0;
    frame_px_count_d = frame_px_count_q;
    err_d            = 1'b0;
    resync           = 1'b0;
    shifted          = {sreg_q[BITS_PER_PIXEL-2:0], (hcnt_q >= H_SPLIT)};
    // Fires once, on the cycle the low run reaches T_LATCH.
    latch_evt        = ~din_s_q && (lcnt_q == L_ARM);

    case (state_q)
      SYNC: begin
        if (~din_s_q && (lcnt_q >= L_ARM))
          state_d = IDLE;
      end
      IDLE: begin
        if (rise)
          state_d = HIGH;
      end
      HIGH: begin
        if (fall) begin
          if ((hcnt_q < H_MIN) || (hcnt_q > H_MAX)) begin
            err_d  = 1'b1;
            resync = 1'b1;
          end else begin
            state_d = LOW;
            if (bit_cnt_q == B_LAST) begin
              bit_cnt_d = '0;
              sreg_d    = '0;
              if (px_cnt_q < C_MAX) begin
                pixel_out_d   = shifted;
                pixel_idx_d   = px_cnt_q[PX_IDX_W-1:0];
                pixel_valid_d = 1'b1;
                px_cnt_d      = px_cnt_q + CW'(1);
              end else begin
                err_d = 1'b1;
              end
            end else begin
              sreg_d    = shifted;
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end
        end else if (hcnt_q > H_MAX) begin
          err_d  = 1'b1;
          resync = 1'b1;
        end
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
        end else if (latch_evt) begin
          frame_done_d     = 1'b1;
          frame_px_count_d = px_cnt_q;
          err_d            = (bit_cnt_q != '0);
          sreg_d           = '0;
          bit_cnt_d        = '0;
          px_cnt_d         = '0;
          state_d          = IDLE;
        end
      end
      default: state_d = SYNC;
    endcase

    if (resync) begin
      state_d   = SYNC;
      sreg_d    = '0;
      bit_cnt_d = '0;
      px_cnt_d  = '0;
    end
  end

  assign pixel_out      = pixel_out_q;
  assign pixel_idx      = pixel_idx_q;
  assign pixel_valid    = pixel_valid_q;
  assign frame_done     = frame_done_q;
  assign frame_px_count = frame_px_count_q;
  assign err_pulse      = err_q;

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Scoreboard bench for ws2812_rx_decoder: a pulse-level protocol model queues expected
// pixel/frame/error events; a negedge monitor pops and compares each DUT strobe.
module tb_ws2812_rx_decoder;

  localparam int TL      = 400;
  localparam int T_MIN   = 15;
  localparam int T_SPLIT = 60;
  localparam int T_MAX   = 120;
  localparam int NPX     = 52;
  localparam int K_PIX   = 0;
  localparam int K_ERR   = 1;
  localparam int K_FRAME = 2;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        din   = 1'b0;
  logic [23:0] pixel_out;
  logic [5:0]  pixel_idx;
  logic        pixel_valid;
  logic        frame_done;
  logic [6:0]  frame_px_count;
  logic        err_pulse;

  ws2812_rx_decoder #(
    .T_MIN_HIGH(T_MIN), .T_SPLIT(T_SPLIT), .T_MAX_HIGH(T_MAX), .T_LATCH(TL),
    .PX_COUNT(NPX), .BITS_PER_PIXEL(24), .PX_IDX_W(6)
  ) dut (
    .clk(clk), .reset(reset), .din(din),
    .pixel_out(pixel_out), .pixel_idx(pixel_idx), .pixel_valid(pixel_valid),
    .frame_done(frame_done), .frame_px_count(frame_px_count), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [23:0] data;
    logic [5:0]  idx;
    logic [6:0]  cnt;
    logic        err;
  } ev_t;

  int  n_tests = 0;
  int  n_fail  = 0;
  ev_t exp_q[$];

  // protocol model state
  bit  armed   = 1'b0;
  bit  seen    = 1'b0;
  bit  bitq[$];
  int  npx     = 0;
  int  low_run = 0;

  logic [23:0] hold_px  = '0;
  logic [5:0]  hold_idx = '0;
  logic [6:0]  hold_cnt = '0;
  ev_t         mon_e;

  task automatic push_ev(input int kind, input logic [23:0] d, input int idx,
                         input int cnt, input bit err);
    ev_t e;
    e.kind = kind; e.data = d; e.idx = 6'(idx); e.cnt = 7'(cnt); e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    armed = 1'b0; seen = 1'b0; bitq.delete(); npx = 0; low_run = 0;
  endtask

  task automatic model_pulse(input int h);
    logic [23:0] w;
    low_run = 0;
    if (!armed) return;
    if (h < T_MIN || h > T_MAX) begin
      push_ev(K_ERR, '0, 0, 0, 1'b0);
      armed = 1'b0; seen = 1'b0; bitq.delete(); npx = 0;
    end else begin
      bitq.push_back(h >= T_SPLIT);
      seen = 1'b1;
      if (bitq.size() == 24) begin
        w = '0;
        for (int i = 0; i < 24; i++) w = {w[22:0], bitq[i]};
        bitq.delete();
        if (npx < NPX) begin
          push_ev(K_PIX, w, npx, 0, 1'b0);
          npx++;
        end else begin
          push_ev(K_ERR, '0, 0, 0, 1'b0);
        end
      end
    end
  endtask

  task automatic model_gap();
    if (armed && seen) push_ev(K_FRAME, '0, 0, npx, bitq.size() != 0);
    bitq.delete(); npx = 0; seen = 1'b0; armed = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_high(input int h);
    model_pulse(h);
    din = 1'b1;
    repeat (h) step();
  endtask

  task automatic drive_low(input int n);
    din = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      low_run++;
      if (low_run == TL) model_gap();
    end
  endtask

  task automatic send_bit(input int h, input int l);
    drive_high(h);
    drive_low(l);
  endtask

  task automatic send_pixel(input logic [23:0] w, input int h0, input int l0,
                            input int h1, input int l1);
    for (int i = 23; i >= 0; i--) begin
      if (w[i]) send_bit(h1, l1);
      else      send_bit(h0, l0);
    end
  endtask

  function automatic int rand_h(input bit b);
    int sel;
    sel = int'($urandom_range(0, 3));
    if (b) return (sel == 0) ? T_SPLIT : (sel == 1) ? T_MAX : int'($urandom_range(T_SPLIT, T_MAX));
    else   return (sel == 0) ? T_MIN : (sel == 1) ? T_SPLIT - 1 : int'($urandom_range(T_MIN, T_SPLIT - 1));
  endfunction

  task automatic send_rand_bits(input int n);
    bit b;
    for (int i = 0; i < n; i++) begin
      b = 1'($urandom_range(0, 1));
      send_bit(rand_h(b), ($urandom_range(0, 30) == 0) ? TL - 1 : int'($urandom_range(2, 100)));
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pixel_out"}, 32'(pixel_out), 0);
    chk({tag, "_pixel_idx"}, 32'(pixel_idx), 0);
    chk({tag, "_pixel_valid"}, 32'(pixel_valid), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_frame_px_count"}, 32'(frame_px_count), 0);
    chk({tag, "_err_pulse"}, 32'(err_pulse), 0);
  endtask

  task automatic wait_drain(input string tag);
    int budget;
    budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_%s: %0d expected events missing", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    din   = 1'b0;
    model_reset();
    repeat (3) step();
    reset = 1'b0;
  endtask

  // monitor
  always @(negedge clk) begin
    if (reset) begin
      hold_px = '0; hold_idx = '0; hold_cnt = '0;
    end else begin
      if (!pixel_valid) begin
        n_tests++;
        if (pixel_out !== hold_px || pixel_idx !== hold_idx) begin
          n_fail++;
          $display("FAIL pixel_hold: got %06h/%0d expected %06h/%0d", pixel_out, pixel_idx, hold_px, hold_idx);
        end
      end
      if (!frame_done) begin
        n_tests++;
        if (frame_px_count !== hold_cnt) begin
          n_fail++;
          $display("FAIL count_hold: got %0d expected %0d", frame_px_count, hold_cnt);
        end
      end
      if (pixel_valid || frame_done || err_pulse) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: pv=%0b fd=%0b err=%0b expected none", pixel_valid, frame_done, err_pulse);
        end else begin
          mon_e = exp_q.pop_front();
          case (mon_e.kind)
            K_PIX: begin
              if (!(pixel_valid && !frame_done && !err_pulse && pixel_out === mon_e.data && pixel_idx === mon_e.idx)) begin
                n_fail++;
                $display("FAIL pixel: got pv=%0b fd=%0b err=%0b data=%06h idx=%0d expected data=%06h idx=%0d",
                         pixel_valid, frame_done, err_pulse, pixel_out, pixel_idx, mon_e.data, mon_e.idx);
              end
              hold_px = mon_e.data; hold_idx = mon_e.idx;
            end
            K_ERR: begin
              if (!(err_pulse && !pixel_valid && !frame_done)) begin
                n_fail++;
                $display("FAIL error: got pv=%0b fd=%0b err=%0b expected lone err_pulse", pixel_valid, frame_done, err_pulse);
              end
            end
            default: begin
              if (!(frame_done && !pixel_valid && err_pulse === mon_e.err && frame_px_count === mon_e.cnt)) begin
                n_fail++;
                $display("FAIL frame: got pv=%0b fd=%0b err=%0b count=%0d expected fd=1 err=%0b count=%0d",
                         pixel_valid, frame_done, err_pulse, frame_px_count, mon_e.err, mon_e.cnt);
              end
              hold_cnt = mon_e.cnt;
            end
          endcase
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int err_w[4];
    int npix;
    err_w[0] = 10; err_w[1] = 130; err_w[2] = 14; err_w[3] = 121;

    repeat (4) step();
    check_zero("reset");
    reset = 1'b0;
    model_reset();

    // single known pixel with nominal timing
    drive_low(TL);
    send_pixel(24'hA5C30F, 40, 85, 80, 45);
    drive_low(TL);

    // split threshold: 59 decodes 0, 60 decodes 1
    send_pixel(24'h5A3C96, T_SPLIT - 1, 45, T_SPLIT, 45);
    drive_low(TL);
    // extreme legal widths
    send_pixel(24'h3C0FF1, T_MIN, 30, T_MAX, 30);
    drive_low(TL);
    wait_drain("basic");

    // traffic right after reset is ignored until a latch gap
    do_reset();
    send_pixel(24'hFFFFFF, 20, 10, 70, 10);
    send_pixel(24'h123456, 20, 10, 70, 10);
    drive_low(TL);
    send_pixel(24'hC0FFEE, 40, 85, 80, 45);
    drive_low(TL);

    // overlong frame
    for (int k = 0; k < 53; k++) send_pixel(24'(k * 24'h010203), T_MIN, 2, T_SPLIT, 2);
    drive_low(TL);
    wait_drain("long_frame");

    // protocol errors force resync
    for (int j = 0; j < 4; j++) begin
      send_rand_bits(3);
      send_bit(err_w[j], 45);
      send_pixel(24'($urandom), 20, 10, 70, 10);
      drive_low(TL);
      send_pixel(24'($urandom), 30, 20, 90, 20);
      drive_low(TL);
    end

    // partial pixel at latch
    send_rand_bits(12);
    drive_low(TL);
    send_pixel(24'($urandom), 30, 20, 90, 20);
    send_pixel(24'($urandom), 30, 20, 90, 20);
    send_rand_bits(12);
    drive_low(TL);

    // randomized frames
    for (int f = 0; f < 4; f++) begin
      npix = int'($urandom_range(1, 3));
      for (int p = 0; p < npix; p++) send_rand_bits(24);
      drive_low(TL);
    end
    wait_drain("random");

    // reset asserted mid-bit
    send_pixel(24'h0F0F0F, 30, 20, 90, 20);
    drive_low(TL);
    send_rand_bits(8);
    wait_drain("pre_reset");
    din = 1'b1;
    repeat (30) step();
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    din = 1'b0;
    model_reset();
    repeat (3) step();
    reset = 1'b0;
    drive_low(TL + 5);
    send_pixel(24'h81E742, 40, 85, 80, 45);
    drive_low(TL + 10);
    wait_drain("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
